// File: rtl/fp_addsub_pipe.sv
// fp_addsub_pipe: pipelined IEEE-754 style add/sub with round-to-nearest-even, fixed latency 4.
// Denormal inputs are flushed to zero; results too small to normalise flush to zero with underflow.
module fp_addsub_pipe #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    localparam int W = 1 + EXP_W + MAN_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         add_start,
    input  logic         mode,
    input  logic [W-1:0] op1,
    input  logic [W-1:0] op2,
    output logic [W-1:0] add_result,
    output logic         add_done,
    output logic         add_overflow,
    output logic         add_underflow,
    output logic         add_invalid
);
    localparam int SW = MAN_W + 4;
    localparam int LW = $clog2(SW + 1);
    localparam int XW = EXP_W + 2;
    localparam logic [EXP_W-1:0] EMAX = '1;

    typedef struct packed {
        logic             v;
        logic             sp;
        logic             inv;
        logic             zs;
        logic             s;
        logic [W-1:0]     spw;
        logic [EXP_W-1:0] e;
    } meta_t;

    logic             v0_q, mode_q;
    logic [W-1:0]     op1_q, op2_q;
    meta_t            m1_d, m1_q, m2_q, m3_q;
    logic [EXP_W-1:0] d1_d, d1_q;
    logic [SW-1:0]    a1_d, b1_d, a1_q, b1_q, a2_q, b2_d, b2_q;
    logic             sub1_d, sub1_q, sub2_q;
    logic [SW:0]      sum3_d, sum3_q;
    logic [LW-1:0]    lz3_d, lz3_q;
    logic [W-1:0]     res_d;
    logic             ovf_d, unf_d, inv_d;

    logic             sa, sb, za, zb, ia, ib, nan, swap;
    logic [EXP_W-1:0] ea, eb;
    logic [SW-1:0]    ga, gb;

    always_comb begin
        sa = op1_q[W-1];
        sb = op2_q[W-1] ^ mode_q;
        za = op1_q[W-2:MAN_W] == '0;
        zb = op2_q[W-2:MAN_W] == '0;
        ea = za ? '0 : op1_q[W-2:MAN_W];
        eb = zb ? '0 : op2_q[W-2:MAN_W];
        ia = op1_q[W-2:0] == {EMAX, {MAN_W{1'b0}}};
        ib = op2_q[W-2:0] == {EMAX, {MAN_W{1'b0}}};
        nan = (op1_q[W-2:MAN_W] == EMAX && !ia) || (op2_q[W-2:MAN_W] == EMAX && !ib) || (ia && ib && sa != sb);
        ga = za ? '0 : {1'b1, op1_q[MAN_W-1:0], 3'b000};
        gb = zb ? '0 : {1'b1, op2_q[MAN_W-1:0], 3'b000};
        swap = {eb, gb} > {ea, ga};
        a1_d = swap ? gb : ga;
        b1_d = swap ? ga : gb;
        d1_d = swap ? eb - ea : ea - eb;
        sub1_d = sa ^ sb;
        m1_d.v = v0_q;
        m1_d.sp = nan || ia || ib;
        m1_d.inv = nan;
        m1_d.zs = sa & sb;
        m1_d.s = swap ? sb : sa;
        m1_d.e = swap ? eb : ea;
        m1_d.spw = nan ? {1'b0, EMAX, 1'b1, {(MAN_W-1){1'b0}}} : {ia ? sa : sb, EMAX, {MAN_W{1'b0}}};
    end

    logic [2*SW-1:0] ext;

    always_comb begin
        ext = {b1_q, {SW{1'b0}}} >> d1_q;
        b2_d = 32'(d1_q) >= MAN_W + 3 ? {{(SW-1){1'b0}}, |b1_q} : {ext[2*SW-1:SW+1], ext[SW] | (|ext[SW-1:0])};
    end

    always_comb begin
        sum3_d = sub2_q ? {1'b0, a2_q} - {1'b0, b2_q} : {1'b0, a2_q} + {1'b0, b2_q};
        lz3_d = LW'(SW);
        for (int i = 0; i < SW; i++) lz3_d = sum3_d[i] ? LW'(SW - 1 - i) : lz3_d;
    end

    logic          carry, up, zero, unf, ovf;
    logic [SW-1:0] nm;
    logic [MAN_W:0] rm;
    logic [XW-1:0] en, ef;

    // nm keeps hidden bit at SW-1 and G,R,S in the low three bits; ef carries a sign bit
    always_comb begin
        carry = sum3_q[SW];
        nm = carry ? {sum3_q[SW:2], sum3_q[1] | sum3_q[0]} : sum3_q[SW-1:0] << lz3_q;
        en = {2'b00, m3_q.e} + (carry ? XW'(1) : -XW'(lz3_q));
        up = nm[2] & (nm[1] | nm[0] | nm[3]);
        rm = {1'b0, nm[SW-2:3]} + (MAN_W+1)'(up);
        ef = en + XW'(rm[MAN_W]);
        zero = !nm[SW-1];
        unf = !zero && (ef[XW-1] || ef == '0);
        ovf = !zero && !unf && ef[EXP_W:0] >= {1'b0, EMAX};
        inv_d = m3_q.inv;
        ovf_d = !m3_q.sp && ovf;
        unf_d = !m3_q.sp && unf;
        res_d = m3_q.sp ? m3_q.spw :
                zero    ? {m3_q.zs, {(W-1){1'b0}}} :
                ovf     ? {m3_q.s, EMAX, {MAN_W{1'b0}}} :
                unf     ? {m3_q.s, {(W-1){1'b0}}} :
                          {m3_q.s, ef[EXP_W-1:0], rm[MAN_W-1:0]};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v0_q          <= 1'b0;
            mode_q        <= 1'b0;
            op1_q         <= '0;
            op2_q         <= '0;
            m1_q          <= '0;
            m2_q          <= '0;
            m3_q          <= '0;
            d1_q          <= '0;
            a1_q          <= '0;
            b1_q          <= '0;
            a2_q          <= '0;
            b2_q          <= '0;
            sub1_q        <= 1'b0;
            sub2_q        <= 1'b0;
            sum3_q        <= '0;
            lz3_q         <= '0;
            add_result    <= '0;
            add_done      <= 1'b0;
            add_overflow  <= 1'b0;
            add_underflow <= 1'b0;
            add_invalid   <= 1'b0;
        end else begin
            v0_q          <= add_start;
            mode_q        <= add_start ? mode : mode_q;
            op1_q         <= add_start ? op1 : op1_q;
            op2_q         <= add_start ? op2 : op2_q;
            m1_q          <= m1_d;
            d1_q          <= d1_d;
            a1_q          <= a1_d;
            b1_q          <= b1_d;
            sub1_q        <= sub1_d;
            m2_q          <= m1_q;
            a2_q          <= a1_q;
            b2_q          <= b2_d;
            sub2_q        <= sub1_q;
            m3_q          <= m2_q;
            sum3_q        <= sum3_d;
            lz3_q         <= lz3_d;
            add_done      <= m3_q.v;
            add_result    <= m3_q.v ? res_d : add_result;
            add_overflow  <= m3_q.v && ovf_d;
            add_underflow <= m3_q.v && unf_d;
            add_invalid   <= m3_q.v && inv_d;
        end
    end
endmodule

// File: tb/tb_fp_addsub_pipe.sv
// tb_fp_addsub_pipe: directed vectors on a single-precision and a half-precision instance.
module tb_fp_addsub_pipe;
    logic        clk = 0, rst = 1, mode = 0, start = 0, start_h = 0;
    logic [31:0] op1 = 0, op2 = 0, res;
    logic [15:0] op1_h = 0, op2_h = 0, res_h;
    logic        done, ovf, unf, inv, done_h, ovf_h, unf_h, inv_h;
    int          n_chk = 0, n_fail = 0;

    always #5 clk = ~clk;

    fp_addsub_pipe dut (
        .clk(clk), .rst(rst), .add_start(start), .mode(mode), .op1(op1), .op2(op2),
        .add_result(res), .add_done(done), .add_overflow(ovf), .add_underflow(unf), .add_invalid(inv)
    );

    fp_addsub_pipe #(.EXP_W(5), .MAN_W(10)) dut_h (
        .clk(clk), .rst(rst), .add_start(start_h), .mode(mode), .op1(op1_h), .op2(op2_h),
        .add_result(res_h), .add_done(done_h), .add_overflow(ovf_h), .add_underflow(unf_h), .add_invalid(inv_h)
    );

    typedef struct packed {
        logic        h;
        logic [31:0] a;
        logic [31:0] b;
        logic        m;
        logic [31:0] r;
        logic [2:0]  f;
    } vec_t;

    vec_t vt[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add_v(input logic h, input logic [31:0] a, input logic [31:0] b, input logic m,
                         input logic [31:0] r, input logic [2:0] f);
        vec_t v;
        v.h = h; v.a = a; v.b = b; v.m = m; v.r = r; v.f = f;
        vt.push_back(v);
    endtask

    task automatic run(input vec_t v, input int idx);
        int c;
        @(negedge clk);
        mode = v.m;
        if (v.h) begin
            op1_h = v.a[15:0]; op2_h = v.b[15:0]; start_h = 1;
        end else begin
            op1 = v.a; op2 = v.b; start = 1;
        end
        for (c = 1; c <= 10; c++) begin
            @(negedge clk);
            start = 0;
            start_h = 0;
            if (v.h ? done_h : done) break;
        end
        check($sformatf("latency[%0d]", idx), c, 5);
        check($sformatf("result[%0d]", idx), v.h ? {16'h0, res_h} : res, v.r);
        check($sformatf("flags[%0d]", idx), v.h ? {29'h0, ovf_h, unf_h, inv_h} : {29'h0, ovf, unf, inv}, {29'h0, v.f});
        @(negedge clk);
        check($sformatf("hold[%0d]", idx),
              v.h ? {12'h0, done_h, ovf_h, unf_h, inv_h, res_h} : {done, ovf, unf, inv, res[27:0]},
              v.h ? {16'h0, v.r[15:0]} : {4'h0, v.r[27:0]});
    endtask

    initial begin
        logic [31:0] tq[3];
        tq[0] = 32'h40000000; tq[1] = 32'h40800000; tq[2] = 32'h40000000;
        // flags column is {overflow, underflow, invalid}
        add_v(0, 32'h3FA00000, 32'h3FC00000, 0, 32'h40300000, 3'b000);
        add_v(0, 32'h3FC00000, 32'h3FA00000, 1, 32'h3E800000, 3'b000);
        add_v(0, 32'h40490FDB, 32'h40490FDB, 1, 32'h00000000, 3'b000);
        add_v(0, 32'h3F800000, 32'h33800000, 0, 32'h3F800000, 3'b000);
        add_v(0, 32'h3F800000, 32'h33C00000, 0, 32'h3F800001, 3'b000);
        add_v(0, 32'h3F800001, 32'h33800000, 0, 32'h3F800002, 3'b000);
        add_v(0, 32'h7F7FFFFF, 32'h7F7FFFFF, 0, 32'h7F800000, 3'b100);
        add_v(0, 32'h7F800000, 32'hFF800000, 0, 32'h7FC00000, 3'b001);
        add_v(0, 32'h7FC00000, 32'h3F800000, 0, 32'h7FC00000, 3'b001);
        add_v(0, 32'h00000001, 32'h00000000, 0, 32'h00000000, 3'b000);
        add_v(0, 32'h80000000, 32'h80000000, 0, 32'h80000000, 3'b000);
        add_v(0, 32'h7F800000, 32'h3F800000, 0, 32'h7F800000, 3'b000);
        add_v(0, 32'h7F800000, 32'hFF800000, 1, 32'h7F800000, 3'b000);
        add_v(0, 32'h00800000, 32'h00C00000, 1, 32'h80000000, 3'b010);
        add_v(0, 32'h3FFFFFFF, 32'h33800000, 0, 32'h40000000, 3'b000);
        add_v(0, 32'h7F7FFFFF, 32'h73000000, 0, 32'h7F800000, 3'b100);
        add_v(0, 32'h3F800000, 32'h0D800000, 0, 32'h3F800000, 3'b000);
        add_v(0, 32'h40000000, 32'h3F800000, 1, 32'h3F800000, 3'b000);
        add_v(0, 32'h3F800000, 32'hBF800000, 0, 32'h00000000, 3'b000);
        add_v(0, 32'hFF800000, 32'h7F800000, 1, 32'hFF800000, 3'b000);
        add_v(1, 32'h3C00, 32'h3C00, 0, 32'h4000, 3'b000);
        add_v(1, 32'h3C00, 32'h1400, 0, 32'h3C01, 3'b000);
        add_v(1, 32'h7BFF, 32'h7BFF, 0, 32'h7C00, 3'b100);
        add_v(1, 32'h7E00, 32'h3C00, 0, 32'h7E00, 3'b001);

        repeat (2) @(negedge clk);
        check("reset_state", {done, ovf, unf, inv, res}, 36'h0);
        check("reset_state_h", {16'h0, done_h, ovf_h, unf_h, inv_h, res_h[11:0]}, 32'h0);
        rst = 0;

        for (int i = 0; i < vt.size(); i++) run(vt[i], i);

        // three back-to-back issues must retire on consecutive cycles in order
        @(negedge clk);
        op1 = 32'h3F800000; op2 = 32'h3F800000; mode = 0; start = 1;
        for (int n = 1; n <= 9; n++) begin
            @(negedge clk);
            if (n == 1) begin op1 = 32'h40000000; op2 = 32'h40000000; end
            if (n == 2) begin op1 = 32'h40400000; op2 = 32'h3F800000; mode = 1; end
            if (n == 3) start = 0;
            check($sformatf("tp_done[%0d]", n), done, n >= 5 && n <= 7);
            if (n >= 5 && n <= 7) check($sformatf("tp_res[%0d]", n), res, tq[n-5]);
        end

        // reset while two operations are in flight flushes them
        @(negedge clk);
        op1 = 32'h3F800000; op2 = 32'h3F800000; mode = 0; start = 1;
        op1_h = 16'h3C00; op2_h = 16'h3C00; start_h = 1;
        @(negedge clk);
        op1 = 32'h40000000; op2 = 32'h40000000;
        @(negedge clk);
        start = 0; start_h = 0;
        @(negedge clk);
        rst = 1;
        #1;
        check("midrst_out", {done, ovf, unf, inv, res}, 36'h0);
        check("midrst_out_h", {12'h0, done_h, ovf_h, unf_h, inv_h, res_h}, 32'h0);
        @(negedge clk);
        rst = 0;
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            check($sformatf("flushed[%0d]", n), {done, done_h}, 2'b00);
        end
        run(vt[17], 100);
        run(vt[20], 101);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/fp_addsub_pipe.md
Name: fp_addsub_pipe

Overview:
- Parametrised, fully pipelined IEEE-754-style floating-point adder/subtractor. Successor to the single-precision combinational add/sub unit.
- Configurable exponent and mantissa widths.
- Accepts one operation per clock on a start/done valid handshake with fixed latency.
- Implements round-to-nearest-even, special-value handling, and overflow/underflow flags.
- Sits between the FP operand registers and the FP result writeback in the arithmetic datapath.

Parameters:
EXP_W, 8, exponent field width in bits
MAN_W, 23, stored mantissa (fraction) width in bits, hidden bit excluded
(Word width W = 1 + EXP_W + MAN_W; default 32. Latency is fixed at 4 and is not a parameter.)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
add_start  in  1  operation valid; op1/op2/mode sampled on the same edge
mode  in  1  0 = op1+op2, 1 = op1-op2 (op2 sign inverted at intake)
op1  in  W  operand 1
op2  in  W  operand 2
add_result  out  W  result, valid when add_done=1
add_done  out  1  one-cycle result-valid pulse per accepted operation
add_overflow  out  1  result overflowed to infinity; qualified by add_done
add_underflow  out  1  nonzero result flushed to zero; qualified by add_done
add_invalid  out  1  NaN result (NaN input, or inf-inf); qualified by add_done

Behaviour:
- Reset: one clock, asynchronous and active-high. All stage valid bits clear. add_result=0, add_done=0, all flags=0, held while rst=1. Reset mid-pipeline discards in-flight operations; no add_done follows for them.
- Handshake: no backpressure. add_start may be high every cycle. add_start high at edge k gives add_done=1 with result and flags during the cycle after edge k+4. Results emerge in issue order. Outputs are registered and hold their last value when add_done=0.
- S1, unpack:
  - Effective sign of b = op2 sign XOR mode.
  - Classify zero (exp=0, denormals flushed to zero), inf (exp all ones, frac=0) and NaN (exp all ones, frac≠0).
  - Swap so that |a| >= |b|, comparing {exp,frac}.
  - d = ea - eb.
  - Significands are {1,frac} extended by 3 bits for guard, round and sticky.
- S2, align: shift b right by d. If d >= MAN_W+3, b becomes 0 and sticky = OR of b. Otherwise sticky = OR of the bits shifted out.
- S3, add: add if signs are equal, otherwise subtract (a-b, always >= 0). Produces a MAN_W+5 bit sum with carry. Leading-zero count is computed in this stage.
- S4, normalise, round and pack:
  - On carry: shift right 1, exp+1, and fold the lost bit into sticky.
  - Otherwise: shift left by the LZC, exp-LZC.
  - Round to nearest even. Round up iff G & (R | S | lsb). A mantissa carry-out from rounding increments exp.
  - Result sign is the sign of a.
  - Exact zero result: sign is +0, except (-0)+(-0) gives -0.
- Exceptions:
  - Any NaN input gives canonical qNaN (exp all ones, frac MSB=1, sign 0) with add_invalid=1.
  - inf plus inf of opposite effective sign gives qNaN with add_invalid=1.
  - A single inf input, or inf plus same-signed inf, passes that inf through with no flags.
- Overflow: final exp >= all ones gives ±inf with add_overflow=1.
- Underflow: final exp <= 0 with a nonzero significand gives ±0 with add_underflow=1.
- Flags are mutually exclusive and all 0 whenever add_done=0.

Test Plan:
- 1.25+1.5: op1=3FA00000, op2=3FC00000, mode=0, add_start at edge k -> add_done exactly at k+4; result 40300000, flags 0.
- Cancellation: 3FC00000-3FA00000 (mode=1) -> 3E800000. 40490FDB-40490FDB -> 00000000 (+0), add_underflow=0.
- Rounding ties: 3F800000+33800000 -> 3F800000 (tie to even). 3F800000+33C00000 -> 3F800001. 3F800001+33800000 -> 3F800002.
- Overflow and specials:
  - 7F7FFFFF+7F7FFFFF -> 7F800000, add_overflow=1.
  - 7F800000+FF800000 -> 7FC00000, add_invalid=1.
  - 7FC00000+3F800000 -> 7FC00000, add_invalid=1.
  - Denormal 00000001+00000000 -> 00000000.
- Throughput and order: add_start high for 3 consecutive cycles with (1+1, 2+2, 3-1) -> add_done high for 3 consecutive cycles starting 4 cycles later, results 40000000, 40800000, 40000000 in order.
- Reset mid-flight: issue 2 ops, assert rst for 1 cycle 2 cycles later -> outputs 0 immediately, no add_done for the flushed ops; a new op issued after release completes normally. Repeat with EXP_W=5, MAN_W=10: 3C00+3C00 -> 4000.
